inst_encoder_loader: RTL and testbench
======================================

// Module: inst_encoder_loader
// PURPOSE
//  Encoder-side counterpart of the immediate generator: packs op/register/immediate fields into
//  32-bit RV32I instruction words and writes them sequentially into instruction memory.
//  Used as a boot/test-program loader ahead of the pipeline: a field stream in, imem writes out.
//  Accepts one instruction per cycle via valid/ready; registered output, 1-cycle latency.
// PARAMETERS
//  DEPTH      64   max instruction words per load session
//  ADDR_W     32   width of imem_addr (byte address)
//  BASE_ADDR  0    byte address of first word written after start
// PORTS
//  clk          in   1       clock, all logic on rising edge
//  rst          in   1       synchronous, active-high reset
//  start        in   1       pulse: begin new load session at BASE_ADDR
//  in_valid     in   1       field beat valid
//  in_ready     out  1       loader can accept a beat
//  in_last      in   1       beat is final instruction of session
//  op_sel       in   3       0 ADD,1 SUB,2 ADDI,3 SRAI,4 LW,5 SW,6 BEQ,7 illegal
//  rd/rs1/rs2   in   5 each  register indices (unused fields ignored)
//  imm          in   32      signed immediate, byte offset for BEQ, shamt for SRAI
//  imem_we      out  1       write strobe, one cycle per word
//  imem_addr    out  ADDR_W  byte address of word
//  imem_wdata   out  32      encoded instruction
//  done         out  1       session complete (level until start/rst)
//  count        out  $clog2(DEPTH+1)  words written this session
//  err_illegal  out  1       sticky: op_sel==7 received
//  err_range    out  1       sticky: immediate out of range (macro only, else 0)
// BEHAVIOUR
//  Reset: state IDLE; in_ready,imem_we,done,err_* =0; imem_addr=BASE_ADDR; imem_wdata=0; count=0.
//  FSM: IDLE -start-> LOAD; LOAD -(accepted beat with in_last) or (count reaches DEPTH)-> DONE;
//   DONE -start-> LOAD. start in any state restarts: addr=BASE_ADDR, count=0, err_* cleared.
//  in_ready = (state==LOAD) && !start. Beat accepted when in_valid && in_ready.
//  Accepted legal beat: next cycle imem_we=1, imem_wdata=encoding, imem_addr=current addr;
//   addr += 4 (wraps mod 2^ADDR_W), count += 1. imem_we deasserts otherwise.
//  Encodings (opcode/funct3/funct7): ADD 0110011/000/0000000, SUB 0110011/000/0100000,
//   ADDI 0010011/000 I-type imm[11:0], SRAI 0010011/101/0100000 shamt=imm[4:0] in [24:20],
//   LW 0000011/010 I-type, SW 0100011/010 {imm[11:5],rs2,rs1,f3,imm[4:0]},
//   BEQ 1100011/000 {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11]}; imm[0] dropped.
//  Illegal op_sel: beat consumed, no write, addr/count unchanged, err_illegal set; in_last still ends session.
//  count==DEPTH: transition to DONE on the same edge the last write is issued; further beats stall.
//  in_last on a dropped beat still moves to DONE. done asserts the cycle after the final write.
//  Reset mid-session: pending write discarded, back to IDLE.
// CONFIGURATION
//  IMM_RANGE_CHECK_EN defined: I/S imm must be in [-2048,2047], SRAI in [0,31], BEQ in
//   [-4096,4094] and even; violation -> beat consumed, no write, err_range set.
//  Not defined: no checks, imm silently truncated to field bits; err_range tied 0.
// TESTING
//  rst, start, ADDI rd=1 rs1=0 imm=5 -> next cycle imem_we=1, addr=0x0, wdata=0x00500093.
//  SRAI rd=2 rs1=1 imm=3 -> wdata=0x4030D113; SW rs1=1 rs2=2 imm=8 -> wdata=0x0020A423.
//  BEQ rs1=1 rs2=2 imm=-8 with in_last -> wdata=0xFE208CE3, done=1 next cycle, count=1.
//  DEPTH=4, stream 6 back-to-back beats -> 4 writes at 0x0,0x4,0x8,0xC; in_ready=0 after 4th; done=1.
//  op_sel=7 mid-stream -> err_illegal=1, no imem_we, next legal word lands at unchanged addr.
//  IMM_RANGE_CHECK_EN: ADDI imm=2048 -> err_range=1, no write; without macro -> wdata=0x80000013.
//  start asserted in LOAD after 2 writes -> addr back to 0x0, count=0, errors cleared.

Source files
------------

// File: rtl/inst_encoder_loader.sv
// rtl/inst_encoder_loader.sv - RV32I field-to-word encoder that loads instruction memory sequentially
//
// Packs op/register/immediate fields into 32-bit RV32I instruction words and
// writes them to consecutive imem word addresses, starting at BASE_ADDR each
// time a load session is started.
//
// Optional feature macro: IMM_RANGE_CHECK_EN
//   defined   : immediates outside their encodable range are dropped and flag err_range
//   undefined : immediates are truncated to their field bits, err_range is tied 0
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   start             pulse: begin a new load session at BASE_ADDR (valid in any state)
//   in_valid/in_ready field-beat handshake; in_last marks the final beat of a session
//   op_sel            0 ADD, 1 SUB, 2 ADDI, 3 SRAI, 4 LW, 5 SW, 6 BEQ, 7 illegal
//   rd, rs1, rs2      register indices
//   imm               signed immediate (byte offset for BEQ, shamt for SRAI)
//   imem_we/addr/wdata registered write port, one strobe per encoded word
//   done              level, session complete until the next start or reset
//   count             words written this session
//   err_illegal       sticky, an op_sel of 7 was consumed
//   err_range         sticky, an out-of-range immediate was consumed

module inst_encoder_loader #(
    parameter int                DEPTH     = 64,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_last,
    input  logic [2:0]                 op_sel,
    input  logic [4:0]                 rd,
    input  logic [4:0]                 rs1,
    input  logic [4:0]                 rs2,
    input  logic [31:0]                imm,
    output logic                       imem_we,
    output logic [ADDR_W-1:0]          imem_addr,
    output logic [31:0]                imem_wdata,
    output logic                       done,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err_illegal,
    output logic                       err_range
);

    localparam int             CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(DEPTH - 1);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_SRAI = 3'd3;
    localparam logic [2:0] OP_LW   = 3'd4;
    localparam logic [2:0] OP_SW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_BAD  = 3'd7;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         enc;
    logic                accept;
    logic                illegal;
    logic                range_bad;
    logic                write_ok;

    assign in_ready = (state_q == S_LOAD) && !start;
    assign accept   = in_valid && in_ready;
    assign illegal  = (op_sel == OP_BAD);
    assign write_ok = accept && !illegal && !range_bad;

    // Field packing. Fields an op does not use are simply not referenced.
    always_comb begin
        enc = '0;
        case (op_sel)
            OP_ADD:  enc = {7'b0000000, rs2, rs1, 3'b000, rd, OPC_OP};
            OP_SUB:  enc = {7'b0100000, rs2, rs1, 3'b000, rd, OPC_OP};
            OP_ADDI: enc = {imm[11:0], rs1, 3'b000, rd, OPC_OP_IMM};
            OP_SRAI: enc = {7'b0100000, imm[4:0], rs1, 3'b101, rd, OPC_OP_IMM};
            OP_LW:   enc = {imm[11:0], rs1, 3'b010, rd, OPC_LOAD};
            OP_SW:   enc = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
            // B-type scatters the offset; bit 0 is implicit zero and dropped.
            OP_BEQ:  enc = {imm[12], imm[10:5], rs2, rs1, 3'b000,
                            imm[4:1], imm[11], OPC_BRANCH};
            default: enc = '0;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    logic signed [31:0] simm;
    logic               err_range_q;

    assign simm      = imm;
    assign err_range = err_range_q;

    always_comb begin
        range_bad = 1'b0;
        case (op_sel)
            OP_ADDI, OP_LW, OP_SW: range_bad = (simm < -2048) || (simm > 2047);
            // Unsigned compare: negative shift amounts are rejected too.
            OP_SRAI:               range_bad = (imm > 32'd31);
            OP_BEQ:                range_bad = (simm < -4096) || (simm > 4094) || imm[0];
            default:               range_bad = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_range_q <= 1'b0;
        end else if (start) begin
            err_range_q <= 1'b0;
        end else if (accept && !illegal && range_bad) begin
            err_range_q <= 1'b1;
        end
    end
`else
    logic unused_imm;

    // High immediate bits only matter to the range check.
    assign unused_imm = ^imm[31:13];
    assign range_bad  = 1'b0;
    assign err_range  = 1'b0;
`endif

    // Next-state logic. start wins from any state. The full-session exit is
    // taken on the accepting edge so the last write and DONE coincide and no
    // further beat can slip in.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = S_LOAD;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if ((accept && in_last) || (write_ok && count == LAST_CNT)) begin
                        state_d = S_DONE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= BASE_ADDR;
            imem_we     <= 1'b0;
            imem_addr   <= BASE_ADDR;
            imem_wdata  <= '0;
            done        <= 1'b0;
            count       <= '0;
            err_illegal <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= (state_d == S_DONE);
            imem_we <= write_ok;
            if (start) begin
                // in_ready is low while start is high, so no write races the restart.
                addr_q      <= BASE_ADDR;
                count       <= '0;
                err_illegal <= 1'b0;
            end else begin
                if (write_ok) begin
                    imem_addr  <= addr_q;
                    imem_wdata <= enc;
                    addr_q     <= addr_q + ADDR_W'(4);
                    count      <= count + CW'(1);
                end
                if (accept && illegal) begin
                    err_illegal <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// tb/tb_inst_encoder_loader.sv - scoreboard bench for inst_encoder_loader
module tb_inst_encoder_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [2:0]  op_sel;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        done;
    logic [2:0]  count;
    logic        err_illegal;
    logic        err_range;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_q[$];
    logic [31:0] exp_addr;
    bit          acc;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit RCHK = 1'b1;
`else
    localparam bit RCHK = 1'b0;
`endif

    inst_encoder_loader #(
        .DEPTH(4),
        .ADDR_W(32),
        .BASE_ADDR(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_last(in_last),
        .op_sel(op_sel),
        .rd(rd),
        .rs1(rs1),
        .rs2(rs2),
        .imm(imm),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .done(done),
        .count(count),
        .err_illegal(err_illegal),
        .err_range(err_range)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && imem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr 0x%08h data 0x%08h", imem_addr, imem_wdata);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    check("wr_addr", imem_addr, e[63:32]);
                    check("wr_data", imem_wdata, e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Presents one beat and holds it until accepted or the budget runs out.
    // Returns at posedge+1 with in_valid still high so beats can go back-to-back.
    task automatic send(input logic [2:0] op, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [31:0] im, input bit last,
                        input bit wr, input logic [31:0] exp_word, input int budget,
                        output bit accepted);
        int n;
        op_sel   = op;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
        imm      = im;
        in_last  = last;
        in_valid = 1'b1;
        accepted = 1'b0;
        n = 0;
        while (!accepted && n < budget) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                accepted = 1'b1;
                if (wr) begin
                    exp_q.push_back({exp_addr, exp_word});
                    exp_addr = exp_addr + 32'd4;
                end
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!accepted) in_valid = 1'b0;
    endtask

    task automatic do_start();
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b1;
        exp_addr = 32'h0;
        @(negedge clk);
        check("ready_during_start", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        op_sel = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0; exp_addr = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_imem_we", {31'b0, imem_we}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_count", {29'b0, count}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_wdata", imem_wdata, 32'h0);
        check("rst_errs", {30'b0, err_illegal, err_range}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("idle_in_ready", {31'b0, in_ready}, 32'd0);
        tick();

        // Session A: ADDI, SRAI, illegal, SW
        do_start();
        send(3'd2, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1, 32'h00500093, 8, acc);
        check("acc_addi", {31'b0, acc}, 32'd1);
        send(3'd3, 5'd2, 5'd1, 5'd0, 32'd3, 1'b0, 1'b1, 32'h4030D113, 8, acc);
        check("acc_srai", {31'b0, acc}, 32'd1);
        send(3'd7, 5'd3, 5'd3, 5'd3, 32'd9, 1'b0, 1'b0, 32'h0, 8, acc);
        check("acc_illegal", {31'b0, acc}, 32'd1);
        send(3'd5, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 1'b1, 32'h0020A423, 8, acc);
        check("acc_sw", {31'b0, acc}, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        check("a_err_illegal", {31'b0, err_illegal}, 32'd1);
        check("a_count", {29'b0, count}, 32'd3);
        check("a_done", {31'b0, done}, 32'd0);
        tick();

        // Restart mid-session
        do_start();
        @(negedge clk);
        check("restart_count", {29'b0, count}, 32'd0);
        check("restart_err", {31'b0, err_illegal}, 32'd0);
        check("restart_done", {31'b0, done}, 32'd0);
        check("restart_ready", {31'b0, in_ready}, 32'd1);
        tick();

        // Session B: single BEQ with in_last
        send(3'd6, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b1, 1'b1, 32'hFE208CE3, 8, acc);
        check("acc_beq", {31'b0, acc}, 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        @(negedge clk);
        check("b_done", {31'b0, done}, 32'd1);
        check("b_count", {29'b0, count}, 32'd1);
        check("b_ready", {31'b0, in_ready}, 32'd0);
        tick();

        // Session C: back-to-back beats past DEPTH=4
        do_start();
        send(3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h002081B3, 8, acc);
        check("acc_add", {31'b0, acc}, 32'd1);
        send(3'd1, 5'd4, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h40208233, 8, acc);
        check("acc_sub", {31'b0, acc}, 32'd1);
        send(3'd4, 5'd5, 5'd1, 5'd0, 32'd16, 1'b0, 1'b1, 32'h0100A283, 8, acc);
        check("acc_lw", {31'b0, acc}, 32'd1);
        send(3'd2, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1, 32'h00500093, 8, acc);
        check("acc_4th", {31'b0, acc}, 32'd1);
        send(3'd0, 5'd6, 5'd1, 5'd2, 32'd0, 1'b0, 1'b0, 32'h0, 4, acc);
        check("stall_5th", {31'b0, acc}, 32'd0);
        send(3'd0, 5'd7, 5'd1, 5'd2, 32'd0, 1'b1, 1'b0, 32'h0, 3, acc);
        check("stall_6th", {31'b0, acc}, 32'd0);
        @(negedge clk);
        check("c_ready", {31'b0, in_ready}, 32'd0);
        check("c_done", {31'b0, done}, 32'd1);
        check("c_count", {29'b0, count}, 32'd4);
        tick();

        // Session D: ADDI imm=2048 (range boundary), final beat
        do_start();
        send(3'd2, 5'd0, 5'd0, 5'd0, 32'd2048, 1'b1, !RCHK, 32'h80000013, 8, acc);
        check("acc_addi2048", {31'b0, acc}, 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        @(negedge clk);
        check("d_done", {31'b0, done}, 32'd1);
        check("d_err_range", {31'b0, err_range}, {31'b0, RCHK});
        check("d_count", {29'b0, count}, RCHK ? 32'd0 : 32'd1);
        repeat (3) tick();
        check("queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
